// File: rtl/main_control_unit_if.sv
// Control-decoder bus: opcode/enable in, registered datapath strobes out.
// MCU_BNE_SPLIT_EN adds the branch_ne strobe.
interface main_control_unit_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AOPW = 3
);
  logic            en;
  logic [OPW-1:0]  opcode;
  logic            reg_dest;
  logic            alusrc;
  logic            mem_to_reg;
  logic            reg_wr;
  logic            mem_rd;
  logic            mem_wr;
  logic            branch;
  logic [AOPW-1:0] alu_op;
  logic            illegal_op;
`ifdef MCU_BNE_SPLIT_EN
  logic            branch_ne;
`endif

  modport master (
    output en, opcode,
    input  reg_dest, alusrc, mem_to_reg, reg_wr, mem_rd, mem_wr, branch, alu_op, illegal_op
`ifdef MCU_BNE_SPLIT_EN
    , branch_ne
`endif
  );

  modport slave (
    input  en, opcode,
    output reg_dest, alusrc, mem_to_reg, reg_wr, mem_rd, mem_wr, branch, alu_op, illegal_op
`ifdef MCU_BNE_SPLIT_EN
    , branch_ne
`endif
  );
endinterface

// File: rtl/main_control_unit.sv
// miniMIPS main control decoder: opcode -> registered datapath strobes, one-cycle latency.
// Optional MCU_BNE_SPLIT_EN adds a registered branch_ne output distinguishing bne from beq.
module main_control_unit #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AOPW = 3
) (
  input logic               clk,
  input logic               rst_n,
  main_control_unit_if.slave bus
);

  localparam logic [AOPW-1:0] AluRtype = 3'b000;
  localparam logic [AOPW-1:0] AluAdd   = 3'b001;
  localparam logic [AOPW-1:0] AluSub   = 3'b010;
  localparam logic [AOPW-1:0] AluAnd   = 3'b011;
  localparam logic [AOPW-1:0] AluOr    = 3'b100;
  localparam logic [AOPW-1:0] AluSlt   = 3'b101;
  localparam logic [AOPW-1:0] AluNor   = 3'b110;

  typedef struct packed {
    logic            reg_dest;
    logic            alusrc;
    logic            mem_to_reg;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic [AOPW-1:0] alu_op;
    logic            illegal_op;
`ifdef MCU_BNE_SPLIT_EN
    logic            branch_ne;
`endif
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Any opcode not listed, including X/Z in simulation, falls to the bubble default.
  always_comb begin
    dec = '0;
    case (bus.opcode)
      4'h0: begin
        dec.reg_dest = 1'b1;
        dec.reg_wr   = 1'b1;
        dec.alu_op   = AluRtype;
      end
      4'h1: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        dec.alu_op = AluAdd;
      end
      4'h2: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        dec.alu_op = AluAnd;
      end
      4'h3: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        dec.alu_op = AluOr;
      end
      4'h4: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        dec.alu_op = AluSlt;
      end
      4'h5: begin
        dec.branch = 1'b1;
        dec.alu_op = AluSub;
      end
      4'h6: begin
        dec.branch = 1'b1;
        dec.alu_op = AluSub;
`ifdef MCU_BNE_SPLIT_EN
        dec.branch_ne = 1'b1;
`endif
      end
      4'h7: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        dec.alu_op = AluNor;
      end
      4'h8: begin
        dec.alusrc     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wr     = 1'b1;
        dec.mem_rd     = 1'b1;
        dec.alu_op     = AluAdd;
      end
      4'h9: begin
        dec.alusrc = 1'b1;
        dec.mem_wr = 1'b1;
        dec.alu_op = AluAdd;
      end
      default: begin
        dec.illegal_op = 1'b1;
      end
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (bus.en) begin
      ctrl_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.reg_dest   = ctrl_q.reg_dest;
  assign bus.alusrc     = ctrl_q.alusrc;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_wr     = ctrl_q.reg_wr;
  assign bus.mem_rd     = ctrl_q.mem_rd;
  assign bus.mem_wr     = ctrl_q.mem_wr;
  assign bus.branch     = ctrl_q.branch;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.illegal_op = ctrl_q.illegal_op;
`ifdef MCU_BNE_SPLIT_EN
  assign bus.branch_ne  = ctrl_q.branch_ne;
`endif

endmodule

// File: tb/tb_main_control_unit.sv
// Scoreboard bench for main_control_unit: driver pushes expected outputs, monitor pops and checks.
module tb_main_control_unit;

  logic clk;
  logic rst_n;
  main_control_unit_if bus ();

  main_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector: {reg_dest, alusrc, mem_to_reg, reg_wr, mem_rd, mem_wr, branch, alu_op[2:0], illegal, bne}
  typedef struct {
    logic [11:0] vec;
    int          step;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] model_state;
  int          n_tests;
  int          n_fail;
  int          step_no;

  function automatic logic [11:0] table_of(input logic [3:0] op);
    logic bne_bit;
`ifdef MCU_BNE_SPLIT_EN
    bne_bit = 1'b1;
`else
    bne_bit = 1'b0;
`endif
    case (op)
      4'd0:    return {7'b1001000, 3'b000, 1'b0, 1'b0};
      4'd1:    return {7'b0101000, 3'b001, 1'b0, 1'b0};
      4'd2:    return {7'b0101000, 3'b011, 1'b0, 1'b0};
      4'd3:    return {7'b0101000, 3'b100, 1'b0, 1'b0};
      4'd4:    return {7'b0101000, 3'b101, 1'b0, 1'b0};
      4'd5:    return {7'b0000001, 3'b010, 1'b0, 1'b0};
      4'd6:    return {7'b0000001, 3'b010, 1'b0, bne_bit};
      4'd7:    return {7'b0101000, 3'b110, 1'b0, 1'b0};
      4'd8:    return {7'b0111100, 3'b001, 1'b0, 1'b0};
      4'd9:    return {7'b0100010, 3'b001, 1'b0, 1'b0};
      default: return {7'b0000000, 3'b000, 1'b1, 1'b0};
    endcase
  endfunction

  function automatic logic [11:0] dut_vec();
    logic bne_act;
`ifdef MCU_BNE_SPLIT_EN
    bne_act = bus.branch_ne;
`else
    bne_act = 1'b0;
`endif
    return {bus.reg_dest, bus.alusrc, bus.mem_to_reg, bus.reg_wr, bus.mem_rd, bus.mem_wr,
            bus.branch, bus.alu_op, bus.illegal_op, bne_act};
  endfunction

  // Drive one cycle of inputs and predict the state after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [3:0] op);
    exp_t item;
    @(negedge clk);
    rst_n      = r;
    bus.en     = e;
    bus.opcode = op;
    if (!r) begin
      model_state = '0;
    end else if (e) begin
      model_state = table_of(op);
    end
    step_no++;
    item.vec  = model_state;
    item.step = step_no;
    sb_q.push_back(item);
  endtask

  // Monitor: one output set per clock, sampled just after the edge.
  initial begin
    exp_t        item;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        item = sb_q.pop_front();
        act  = dut_vec();
        n_tests++;
        if (act !== item.vec) begin
          n_fail++;
          $display("FAIL outputs step %0d: got %b required %b", item.step, act, item.vec);
        end
        n_tests++;
        if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) begin
          n_fail++;
          $display("FAIL inv_mem step %0d: got mem_rd=%b mem_wr=%b required not both 1",
                   item.step, bus.mem_rd, bus.mem_wr);
        end
        n_tests++;
        if (bus.reg_wr === 1'b1 && (bus.mem_wr === 1'b1 || bus.branch === 1'b1)) begin
          n_fail++;
          $display("FAIL inv_regwr step %0d: got reg_wr=%b mem_wr=%b branch=%b required exclusive",
                   item.step, bus.reg_wr, bus.mem_wr, bus.branch);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sweep [10];
    int         drain;
    n_tests     = 0;
    n_fail      = 0;
    step_no     = 0;
    model_state = '0;
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.opcode  = 4'h0;
    sweep = '{4'd0, 4'd8, 4'd9, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};

    // Reset, then first R-type decode.
    step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b1, 4'd0);
    // Defined table sweep.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, sweep[i]);
    // Undefined sweep, then a legal opcode clears illegal_op.
    for (int i = 10; i < 16; i++) step(1'b1, 1'b1, 4'(i));
    step(1'b1, 1'b1, 4'd1);
    // Stall holds sw outputs while opcode changes.
    step(1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd0);
    // Reset wins over en mid-stream.
    step(1'b1, 1'b1, 4'd8);
    step(1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b1, 4'd0);
    // Reset while stalled still clears.
    step(1'b1, 1'b1, 4'd8);
    step(1'b0, 1'b0, 4'd8);
    step(1'b1, 1'b0, 4'd8);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    drain = 0;
    while (sb_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      #2;
      drain++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
